// File: rtl/r2sdf_bf_stage_pkg.sv
// Shared types and helpers for the R2SDF FFT stage family.
package r2sdf_bf_stage_pkg;

  localparam int unsigned FPT_W    = 16;
  localparam int unsigned FPT_FRAC = 14;

  typedef logic signed [FPT_W-1:0] fpt;

  typedef struct packed {
    fpt re;
    fpt im;
  } cplx_t;

  // Reverse the low n bits of i.
  function automatic int unsigned bitrev(input int unsigned i, input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned b = 0; b < n; b++) begin
      r = (r << 1) | ((i >> b) & 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/gen_shuffle_idx.sv
// Bit-reversal index map used to reorder the final FFT stage output.
module gen_shuffle_idx
  import r2sdf_bf_stage_pkg::*;
#(
  parameter int unsigned N = 3
) (
  output logic [2**N-1:0][N-1:0] shuffle_idx
);

  // Purely combinational table: entry i holds bitrev(i).
  always_comb begin
    shuffle_idx = '0;
    for (int unsigned i = 0; i < 2**N; i++) begin
      shuffle_idx[i] = N'(bitrev(i, N));
    end
  end

endmodule

// File: rtl/r2sdf_bf_stage_cplx_mul.sv
// Complex sample times conjugate twiddle (cos - j*sin), truncating FRAC bits.
module cplx_mul #(
  parameter int unsigned W    = 16,
  parameter int unsigned FRAC = 14
) (
  input  logic        [2*W-1:0] x,
  input  logic signed [W-1:0]   tw_cos,
  input  logic signed [W-1:0]   tw_sin,
  output logic        [2*W-1:0] y_c
);

  logic signed [W-1:0]   xr;
  logic signed [W-1:0]   xi;
  logic signed [2*W-1:0] acc_re;
  logic signed [2*W-1:0] acc_im;

  // Full-width products, arithmetic shift, keep the low W bits.
  always_comb begin
    xr     = x[2*W-1:W];
    xi     = x[W-1:0];
    acc_re = (2*W)'(xr * tw_cos) + (2*W)'(xi * tw_sin);
    acc_im = (2*W)'(xi * tw_cos) - (2*W)'(xr * tw_sin);
    y_c    = {W'(acc_re >>> FRAC), W'(acc_im >>> FRAC)};
  end

endmodule

// File: rtl/r2sdf_bf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage.
// Optional debug taps: define BF_STAGE_DEBUG_EN to add _db_* outputs.
module r2sdf_bf_stage
  import r2sdf_bf_stage_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned STAGE = 1,
  parameter int unsigned W     = FPT_W,
  parameter int unsigned FRAC  = FPT_FRAC
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [2*W-1:0]                    ip,
  input  logic                              start_ip,
  input  logic [2**(STAGE-1)-1:0][W-1:0]    cos_arr,
  input  logic [2**(STAGE-1)-1:0][W-1:0]    sin_arr,
  output logic [2*W-1:0]                    op,
  output logic                              start_op
`ifdef BF_STAGE_DEBUG_EN
  ,
  output logic [3*W-1:0]                    _db_neg_product,
  output logic [2*W-1:0]                    _db_trig,
  output logic [W-1:0]                      _db_neg_sum
`endif
);

  localparam int unsigned D  = 2**(STAGE-1);
  localparam int unsigned KW = (STAGE > 1) ? STAGE - 1 : 1;

  if (STAGE < 1 || STAGE > N) begin : g_bad_stage
    $error("r2sdf_bf_stage: STAGE must lie in 1..N");
  end

  logic [STAGE-1:0]       c_q;
  logic [STAGE-1:0]       c_eff;
  logic [KW-1:0]          k;
  logic                   phase2;
  logic                   armed_q;
  logic                   fire;
  logic signed [W-1:0]    tw_cos;
  logic signed [W-1:0]    tw_sin;
  logic [2*W-1:0]         b_c;
  logic [D-1:0][2*W-1:0]  fifo_q;
  logic [2*W-1:0]         head;
  logic signed [W-1:0]    a_re;
  logic signed [W-1:0]    a_im;
  logic signed [W-1:0]    b_re;
  logic signed [W-1:0]    b_im;
  logic [2*W-1:0]         push_c;
  logic [2*W-1:0]         op_d;

  // Sample counter: start_ip forces position 0 on the cycle it is seen.
  always_comb begin
    c_eff  = start_ip ? '0 : c_q;
    k      = (D == 1) ? '0 : KW'(c_eff);
    phase2 = (c_eff >= STAGE'(D));
    fire   = armed_q && (c_eff == STAGE'(D));
    tw_cos = cos_arr[k];
    tw_sin = sin_arr[k];
  end

  cplx_mul #(.W(W), .FRAC(FRAC)) u_mul (
    .x      (ip),
    .tw_cos (tw_cos),
    .tw_sin (tw_sin),
    .y_c    (b_c)
  );

  // Butterfly: phase 1 loads the delay line, phase 2 emits sum and feeds back difference.
  always_comb begin
    head   = fifo_q[D-1];
    a_re   = head[2*W-1:W];
    a_im   = head[W-1:0];
    b_re   = b_c[2*W-1:W];
    b_im   = b_c[W-1:0];
    push_c = ip;
    op_d   = head;
    if (phase2) begin
      op_d   = {W'(a_re + b_re), W'(a_im + b_im)};
      push_c = {W'(a_re - b_re), W'(a_im - b_im)};
    end
  end

  // Counter, delay line, output and frame-marker registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q      <= '0;
      armed_q  <= 1'b0;
      start_op <= 1'b0;
      op       <= '0;
      fifo_q   <= '0;
    end else begin
      c_q      <= c_eff + STAGE'(1);
      armed_q  <= start_ip || (armed_q && !fire);
      start_op <= fire;
      op       <= op_d;
      for (int i = int'(D) - 1; i >= 1; i--) begin
        fifo_q[i] <= fifo_q[i-1];
      end
      fifo_q[0] <= push_c;
    end
  end

`ifdef BF_STAGE_DEBUG_EN
  logic signed [W-1:0]   dbg_xr;
  logic signed [W-1:0]   dbg_xi;
  logic signed [2*W-1:0] dbg_rc;
  logic signed [2*W-1:0] dbg_is;
  logic signed [2*W-1:0] dbg_rs;

  // Observation taps for twiddle and butterfly internals.
  always_comb begin
    dbg_xr          = ip[2*W-1:W];
    dbg_xi          = ip[W-1:0];
    dbg_rc          = (2*W)'(dbg_xr * tw_cos);
    dbg_is          = (2*W)'(dbg_xi * tw_sin);
    dbg_rs          = (2*W)'(dbg_xr * tw_sin);
    _db_neg_product = {W'(-(dbg_rc >>> FRAC)), W'(-(dbg_is >>> FRAC)), W'(-(dbg_rs >>> FRAC))};
    _db_trig        = {tw_cos, tw_sin};
    _db_neg_sum     = W'(-(a_re + b_re));
  end
`endif

endmodule

// File: tb/tb_r2sdf_bf_stage.sv
// Bench for r2sdf_bf_stage (STAGE 1 and 2) and gen_shuffle_idx.
module tb_r2sdf_bf_stage;
  import r2sdf_bf_stage_pkg::*;

  logic             clk;
  logic             rst_n;
  logic [31:0]      ip;
  logic             start_ip;
  logic [0:0][15:0] cos1, sin1;
  logic [1:0][15:0] cos2, sin2;
  logic [31:0]      op1, op2;
  logic             st1, st2;
  logic [7:0][2:0]  shuf;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: history of values pushed into each delay line.
  int cosv [2][2];
  int sinv [2][2];
  int hre  [2][4096];
  int him  [2][4096];
  int last_start [2];
  int valid_from;
  int e;
  int exp_re [2];
  int exp_im [2];
  bit exp_st [2];

  r2sdf_bf_stage #(.N(3), .STAGE(1), .W(16), .FRAC(14)) dut1 (
    .clk(clk), .rst_n(rst_n), .ip(ip), .start_ip(start_ip),
    .cos_arr(cos1), .sin_arr(sin1), .op(op1), .start_op(st1)
  );

  r2sdf_bf_stage #(.N(3), .STAGE(2), .W(16), .FRAC(14)) dut2 (
    .clk(clk), .rst_n(rst_n), .ip(ip), .start_ip(start_ip),
    .cos_arr(cos2), .sin_arr(sin2), .op(op2), .start_op(st2)
  );

  gen_shuffle_idx #(.N(3)) u_shuf (.shuffle_idx(shuf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int wrap16(input longint v);
    return int'(shortint'(v));
  endfunction

  function automatic int sre(input logic [31:0] v);
    cplx_t c;
    c = cplx_t'(v);
    return int'(c.re);
  endfunction

  function automatic int sim(input logic [31:0] v);
    cplx_t c;
    c = cplx_t'(v);
    return int'(c.im);
  endfunction

  task automatic check_all();
    check("s1_re", sre(op1), exp_re[0]);
    check("s1_im", sim(op1), exp_im[0]);
    check("s1_start", st1, exp_st[0]);
    check("s2_re", sre(op2), exp_re[1]);
    check("s2_im", sim(op2), exp_im[1]);
    check("s2_start", st2, exp_st[1]);
  endtask

  // Drive one sample at the falling edge, predict, clock, compare.
  task automatic cycle(input int re, input int im, input bit st);
    ip       = {16'(re), 16'(im)};
    start_ip = st;
    for (int s = 0; s < 2; s++) begin
      int d, org, c, k, ar, ai, br, bi;
      longint pr, pi;
      d = 1 << s;
      if (st) last_start[s] = e;
      org = (last_start[s] >= 0) ? last_start[s] : valid_from;
      c   = (e - org) % (2 * d);
      k   = c % d;
      pr  = longint'(re) * cosv[s][k] + longint'(im) * sinv[s][k];
      pi  = longint'(im) * cosv[s][k] - longint'(re) * sinv[s][k];
      br  = wrap16(pr >>> 14);
      bi  = wrap16(pi >>> 14);
      ar  = (e - d >= valid_from) ? hre[s][e-d] : 0;
      ai  = (e - d >= valid_from) ? him[s][e-d] : 0;
      if (c < d) begin
        exp_re[s] = ar;
        exp_im[s] = ai;
        hre[s][e] = re;
        him[s][e] = im;
      end else begin
        exp_re[s] = wrap16(ar + br);
        exp_im[s] = wrap16(ai + bi);
        hre[s][e] = wrap16(ar - br);
        him[s][e] = wrap16(ai - bi);
      end
      exp_st[s] = (last_start[s] >= 0) && (e - last_start[s] == d);
    end
    e++;
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  // Hold reset for n clocks with random input, then release at a falling edge.
  task automatic reset_hold(input int n);
    rst_n = 1'b0;
    for (int j = 0; j < n; j++) begin
      ip       = $urandom;
      start_ip = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("rst_op1", op1, 0);
      check("rst_op2", op2, 0);
      check("rst_st1", st1, 0);
      check("rst_st2", st2, 0);
      @(negedge clk);
    end
    rst_n         = 1'b1;
    start_ip      = 1'b0;
    ip            = '0;
    valid_from    = e;
    last_start[0] = -1;
    last_start[1] = -1;
  endtask

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin
    int ref_idx [8];
    ref_idx = '{0, 4, 2, 6, 1, 5, 3, 7};
    e = 0;
    cos1[0] = 16'd16384; sin1[0] = 16'd0;
    cos2[0] = 16'd16384; cos2[1] = 16'd0;
    sin2[0] = 16'd0;     sin2[1] = 16'd16384;
    cosv[0][0] = 16384; sinv[0][0] = 0; cosv[0][1] = 0; sinv[0][1] = 0;
    cosv[1][0] = 16384; cosv[1][1] = 0;
    sinv[1][0] = 0;     sinv[1][1] = 16384;
    rst_n    = 1'b0;
    start_ip = 1'b0;
    ip       = '0;

    @(negedge clk);
    reset_hold(4);

    // Zero input after release keeps the outputs at zero.
    for (int j = 0; j < 4; j++) begin
      cycle(0, 0, 1'b0);
      check("zero_op2", op2, 0);
    end

    // STAGE 1 directed: 4096 then 8192.
    cycle(4096, 0, 1'b1);
    cycle(8192, 0, 1'b0);
    check("d1_sum", sre(op1), 12288);
    check("d1_start", st1, 1);
    cycle(0, 0, 1'b0);
    check("d1_diff", sre(op1), -4096);

    // STAGE 2 directed: 4096, 0, 4096, 4096.
    cycle(4096, 0, 1'b1);
    cycle(0, 0, 1'b0);
    cycle(4096, 0, 1'b0);
    check("d2_o0_re", sre(op2), 8192);
    check("d2_o0_im", sim(op2), 0);
    check("d2_start", st2, 1);
    cycle(4096, 0, 1'b0);
    check("d2_o1_re", sre(op2), 0);
    check("d2_o1_im", sim(op2), -4096);
    cycle(0, 0, 1'b0);
    check("d2_o2_re", sre(op2), 0);
    check("d2_o2_im", sim(op2), 0);
    cycle(0, 0, 1'b0);
    check("d2_o3_re", sre(op2), 0);
    check("d2_o3_im", sim(op2), 4096);

    // Framing: start at 0 and 5, markers at 2 and 7 only.
    for (int j = 0; j < 10; j++) begin
      cycle(rnd16(), rnd16(), (j == 0) || (j == 5));
      check("frame_st2", st2, (j == 2) || (j == 7));
    end

    // Randomized streaming with occasional resync pulses.
    for (int j = 0; j < 300; j++) begin
      cycle(rnd16(), rnd16(), ($urandom_range(0, 9) == 0));
    end

    // Asynchronous reset mid-frame clears the outputs without a clock edge.
    cycle(rnd16(), rnd16(), 1'b1);
    cycle(rnd16(), rnd16(), 1'b0);
    cycle(rnd16(), rnd16(), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_op1", op1, 0);
    check("async_op2", op2, 0);
    check("async_st2", st2, 0);
    @(negedge clk);
    reset_hold(2);
    cycle(0, 0, 1'b1);
    for (int j = 0; j < 5; j++) begin
      cycle(0, 0, 1'b0);
      check("drain_op2", op2, 0);
    end

    // Random run after reset, including stretches without any start pulse.
    for (int j = 0; j < 150; j++) begin
      cycle(rnd16(), rnd16(), (j > 40) && ($urandom_range(0, 12) == 0));
    end

    for (int i = 0; i < 8; i++) begin
      check("shuffle_idx", shuf[i], ref_idx[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
